// File: rtl/uart_operand_rx_pkg.sv
// Shared types and defaults for the UART operand receiver.
// Holds the FSM state type, the operand pair, and the byte-unpacking helper.
package uart_operand_rx_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DEFAULT_SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic [3:0] multiplier;
        logic [3:0] multiplicand;
    } operands_t;

    // High nibble is operand A, low nibble operand B.
    function automatic operands_t unpack_byte(input logic [7:0] b);
        operands_t ops;
        ops.multiplier   = b[7:4];
        ops.multiplicand = b[3:0];
        return ops;
    endfunction

endpackage

// File: rtl/uart_operand_rx_if.sv
// Serial line in, unpacked operands and status out.
// The receiver uses the slave modport; whoever drives rx uses master.
interface uart_operand_rx_if;

    logic       rx;
    logic [3:0] multiplier;
    logic [3:0] multiplicand;
    logic       op_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx,
        input  multiplier,
        input  multiplicand,
        input  op_valid,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output multiplier,
        output multiplicand,
        output op_valid,
        output frame_err,
        output rx_busy
    );

endinterface

// File: rtl/uart_operand_rx_sync.sv
// Metastability synchroniser for the asynchronous rx line.
// Resets to all ones so a reset never looks like a start bit.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_async};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_operand_rx.sv
// 8N1 UART receiver that unpacks each good byte into two 4-bit Booth operands.
// Operands hold between bytes; op_valid / frame_err are single-cycle pulses.
module uart_operand_rx
    import uart_operand_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    uart_operand_rx_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_async (bus.rx),
        .rx_s     (rx_s)
    );

    rx_state_t        state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    operands_t        ops_q,       ops_d;
    logic             op_valid_q,  op_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q,   rx_busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        ops_d       = ops_q;
        op_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_busy_d   = rx_busy_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    rx_busy_d = 1'b1;
                end
            end

            // Re-check the line half a bit in so short glitches are rejected
            // and later samples land mid-bit.
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = S_IDLE;
                        rx_busy_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        ops_d      = unpack_byte(shift_q);
                        op_valid_d = 1'b1;
                        state_d    = S_IDLE;
                        rx_busy_d  = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A low stop bit may be a break; wait for the line to recover.
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d   = S_IDLE;
                    rx_busy_d = 1'b0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            ops_q       <= '0;
            op_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            ops_q       <= ops_d;
            op_valid_q  <= op_valid_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    assign bus.multiplier   = ops_q.multiplier;
    assign bus.multiplicand = ops_q.multiplicand;
    assign bus.op_valid     = op_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_operand_rx.sv
// Bench for uart_operand_rx: directed frames then random bytes and stop bits,
// checked against a byte-level model of operands, pulse counts and latency.
module tb_uart_operand_rx;

    localparam int CPB  = 8;
    localparam int SYNC = 2;
    // Pulse arrives 9.5 bit times + synchroniser + 1 register after rx falls.
    localparam int LAT  = (19 * CPB) / 2 + SYNC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    uart_operand_rx_if bus ();

    uart_operand_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   op_cnt = 0, fe_cnt = 0, last_op_cyc = -1, last_fe_cyc = -1;
    int   both_cnt = 0, wide_cnt = 0, busy_cycles = 0;
    logic prev_op = 1'b0, prev_fe = 1'b0;

    always @(negedge clk) begin
        if (bus.op_valid === 1'b1) begin
            op_cnt      <= op_cnt + 1;
            last_op_cyc <= cyc;
        end
        if (bus.frame_err === 1'b1) begin
            fe_cnt      <= fe_cnt + 1;
            last_fe_cyc <= cyc;
        end
        if (bus.op_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt <= both_cnt + 1;
        if ((bus.op_valid === 1'b1 && prev_op) || (bus.frame_err === 1'b1 && prev_fe))
            wide_cnt <= wide_cnt + 1;
        prev_op <= (bus.op_valid === 1'b1);
        prev_fe <= (bus.frame_err === 1'b1);
        if (bus.rx_busy === 1'b1) busy_cycles <= busy_cycles + 1;
    end

    int         n_cmp = 0, n_err = 0;
    int         exp_op = 0, exp_fe = 0, t0 = 0;
    logic [3:0] exp_a = '0, exp_b = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        t0     = cyc;
        bus.rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            wait_cycles(CPB);
        end
        bus.rx = stop;
        wait_cycles(CPB);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input logic stop);
        #1;
        if (stop) begin
            exp_a = b[7:4];
            exp_b = b[3:0];
            exp_op++;
        end else begin
            exp_fe++;
        end
        check({tag, "_op_cnt"}, op_cnt, exp_op);
        check({tag, "_fe_cnt"}, fe_cnt, exp_fe);
        check({tag, "_multiplier"}, 32'(bus.multiplier), 32'(exp_a));
        check({tag, "_multiplicand"}, 32'(bus.multiplicand), 32'(exp_b));
        if (stop) check({tag, "_op_latency"}, last_op_cyc - t0, LAT);
        else      check({tag, "_fe_latency"}, last_fe_cyc - t0, LAT);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_multiplier"}, 32'(bus.multiplier), 32'(exp_a));
        check({tag, "_multiplicand"}, 32'(bus.multiplicand), 32'(exp_b));
        check({tag, "_op_valid"}, 32'(bus.op_valid), 0);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 0);
        check({tag, "_rx_busy"}, 32'(bus.rx_busy), 0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        logic [7:0] v;
        int         bc;

        bus.rx = 1'b1;
        rst    = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        #1;
        check_idle_outputs("reset");
        wait_cycles(50);
        #1;
        check_idle_outputs("idle50");
        check("idle50_op_cnt", op_cnt, 0);
        check("idle50_fe_cnt", fe_cnt, 0);
        check("idle50_busy_cycles", busy_cycles, 0);

        send_frame(8'h7E, 1'b1);
        check_frame("b7e", 8'h7E, 1'b1);
        check("b7e_mult_const", 32'(bus.multiplier), 32'h7);
        check("b7e_mcand_const", 32'(bus.multiplicand), 32'hE);
        send_frame(8'hF2, 1'b1);
        check_frame("bf2", 8'hF2, 1'b1);
        check("bf2_mult_const", 32'(bus.multiplier), 32'hF);
        check("bf2_mcand_const", 32'(bus.multiplicand), 32'h2);

        send_frame(8'hA5, 1'b0);
        check_frame("ba5_bad_stop", 8'hA5, 1'b0);
        wait_cycles(30);
        #1;
        check("wait_idle_busy_low_line", 32'(bus.rx_busy), 1);
        bus.rx = 1'b1;
        wait_cycles(SYNC);
        #1;
        check("wait_idle_busy_before_exit", 32'(bus.rx_busy), 1);
        wait_cycles(1);
        #1;
        check("wait_idle_exit", 32'(bus.rx_busy), 0);
        check("wait_idle_op_cnt", op_cnt, exp_op);
        wait_cycles(5);

        bc     = busy_cycles;
        bus.rx = 1'b0;
        wait_cycles(2);
        bus.rx = 1'b1;
        wait_cycles(20);
        #1;
        check("glitch_busy_seen", 32'(busy_cycles > bc), 1);
        check_idle_outputs("glitch");
        check("glitch_op_cnt", op_cnt, exp_op);
        check("glitch_fe_cnt", fe_cnt, exp_fe);

        v      = 8'h33;
        bus.rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx = v[i];
            wait_cycles(CPB);
        end
        bus.rx = v[4];
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(1);
        rst    = 1'b0;
        bus.rx = 1'b1;
        #1;
        exp_a = '0;
        exp_b = '0;
        check_idle_outputs("midframe_reset");
        wait_cycles(20);
        #1;
        check("midframe_reset_op_cnt", op_cnt, exp_op);
        check("midframe_reset_fe_cnt", fe_cnt, exp_fe);
        send_frame(8'h21, 1'b1);
        check_frame("b21", 8'h21, 1'b1);

        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs);
            check_frame("rand", rb, rs);
            if (!rs) begin
                wait_cycles($urandom_range(0, 10));
                bus.rx = 1'b1;
                wait_cycles($urandom_range(4, 10));
            end else begin
                wait_cycles($urandom_range(0, 5));
            end
        end

        wait_cycles(CPB * 12);
        #1;
        check("final_op_cnt", op_cnt, exp_op);
        check("final_fe_cnt", fe_cnt, exp_fe);
        check("pulses_overlap", both_cnt, 0);
        check("pulse_width", wide_cnt, 0);
        check("final_rx_busy", 32'(bus.rx_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
